// File: rtl/eth_fifo_pkg.sv
// Shared types for the Ethernet RX packet FIFO write side.
package eth_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fifo_pckt_wr_ctrl.sv
// Packet-aware FIFO write controller: stores good frames, rolls back bad or
// overflowing ones, and counts committed and dropped frames.
module fifo_pckt_wr_ctrl
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    input  logic                  fifo_full,
    input  logic                  fifo_almost_full,
    output logic                  fifo_write,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  latch_addr,
    output logic                  drop_pckt,
    output logic [CNT_WIDTH-1:0]  good_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    wr_state_e state_q;
    wr_state_e state_d;
    logic      good_inc;
    logic      drop_inc;

    // The MAC cannot be back-pressured, so ready only reflects reset.
    assign s_axis_tready = reset_n;
    assign fifo_wdata    = s_axis_tdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        fifo_write = 1'b0;
        latch_addr = 1'b0;
        drop_pckt  = 1'b0;
        good_inc   = 1'b0;
        drop_inc   = 1'b0;
        if (reset_n && s_axis_tvalid) begin
            case (state_q)
                IDLE: begin
                    // Nothing is stored yet, so a refused frame needs no rollback.
                    if (!s_axis_tlast) begin
                        if (fifo_almost_full) begin
                            state_d = DROP;
                        end else begin
                            fifo_write = 1'b1;
                            state_d    = WRITE;
                        end
                    end else if (!s_axis_tuser && !fifo_almost_full) begin
                        fifo_write = 1'b1;
                        latch_addr = 1'b1;
                        good_inc   = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                WRITE: begin
                    if (!s_axis_tlast) begin
                        if (fifo_full) begin
                            drop_pckt = 1'b1;
                            state_d   = DROP;
                        end else begin
                            fifo_write = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        if (!s_axis_tuser && !fifo_full) begin
                            fifo_write = 1'b1;
                            latch_addr = 1'b1;
                            good_inc   = 1'b1;
                        end else begin
                            drop_pckt = 1'b1;
                            drop_inc  = 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_good_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (good_inc),
        .count   (good_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (drop_inc),
        .count   (drop_cnt)
    );

endmodule

// File: tb/tb_fifo_pckt_wr_ctrl.sv
// Bench for fifo_pckt_wr_ctrl: directed frame table, reset corners, then
// random beats against a frame-level reference model.
module tb_fifo_pckt_wr_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser, full, afull;

    logic        tready, wr, latch, dropp;
    logic [7:0]  wdata;
    logic [15:0] good16, drop16;
    logic        tready_s, wr_s, latch_s, dropp_s;
    logic [7:0]  wdata_s;
    logic [1:0]  good2, drop2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame-level flags plus unbounded frame tallies.
    bit m_storing;
    bit m_discarding;
    int m_good;
    int m_drop;

    always #5 clk = ~clk;

    fifo_pckt_wr_ctrl dut (
        .clk(clk), .reset_n(reset_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tready(tready),
        .fifo_full(full), .fifo_almost_full(afull), .fifo_write(wr), .fifo_wdata(wdata),
        .latch_addr(latch), .drop_pckt(dropp), .good_cnt(good16), .drop_cnt(drop16)
    );

    fifo_pckt_wr_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tready(tready_s),
        .fifo_full(full), .fifo_almost_full(afull), .fifo_write(wr_s), .fifo_wdata(wdata_s),
        .latch_addr(latch_s), .drop_pckt(dropp_s), .good_cnt(good2), .drop_cnt(drop2)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Frame rules: a frame is kept only if every beat fits and its end is clean;
    // a frame refused at its first beat never reached the FIFO so needs no rollback.
    task automatic model_step(input bit rst, input bit v, input bit l, input bit u,
                              input bit f, input bit af,
                              output bit ew, output bit el, output bit ed);
        ew = 0; el = 0; ed = 0;
        if (!rst) begin
            m_storing = 0; m_discarding = 0; m_good = 0; m_drop = 0;
        end else if (v) begin
            if (m_discarding) begin
                if (l) begin m_drop++; m_discarding = 0; end
            end else begin
                bit blocked;
                blocked = m_storing ? f : af;
                if (l) begin
                    if (!u && !blocked) begin ew = 1; el = 1; m_good++; end
                    else begin ed = m_storing; m_drop++; end
                    m_storing = 0;
                end else if (blocked) begin
                    ed = m_storing; m_storing = 0; m_discarding = 1;
                end else begin
                    ew = 1; m_storing = 1;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit l, input bit u,
                        input bit f, input bit af, input logic [7:0] d,
                        input bit use_tab, input bit tw, input bit tl, input bit td);
        bit ew, el, ed;
        @(negedge clk);
        reset_n = rst; tvalid = v; tlast = l; tuser = u; full = f; afull = af; tdata = d;
        #1;
        check("good_cnt",       int'(good16), sat(m_good, 65535));
        check("drop_cnt",       int'(drop16), sat(m_drop, 65535));
        check("good_cnt_sat",   int'(good2),  sat(m_good, 3));
        check("drop_cnt_sat",   int'(drop2),  sat(m_drop, 3));
        check("tready",         int'(tready), int'(rst));
        check("tready_sat",     int'(tready_s), int'(rst));
        check("wdata",          int'(wdata),  int'(d));
        model_step(rst, v, l, u, f, af, ew, el, ed);
        if (use_tab) begin
            ew = tw; el = tl; ed = td;
        end
        check("fifo_write",     int'(wr),      int'(ew));
        check("latch_addr",     int'(latch),   int'(el));
        check("drop_pckt",      int'(dropp),   int'(ed));
        check("fifo_write_sat", int'(wr_s),    int'(ew));
        check("drop_pckt_sat",  int'(dropp_s), int'(ed));
    endtask

    typedef struct {
        bit v, l, u, f, af;
        logic [7:0] d;
        bit w, la, dp;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(bit v, bit l, bit u, bit f, bit af, logic [7:0] d,
                                bit w, bit la, bit dp);
        vec_t r;
        r.v = v; r.l = l; r.u = u; r.f = f; r.af = af; r.d = d;
        r.w = w; r.la = la; r.dp = dp;
        return r;
    endfunction

    initial begin
        // 5-beat good frame with an idle gap mid-frame
        tab.push_back(mk(1,0,0,0,0,8'h11, 1,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h12, 1,0,0));
        tab.push_back(mk(0,0,0,0,0,8'hEE, 0,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h13, 1,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h14, 1,0,0));
        tab.push_back(mk(1,1,0,0,0,8'h15, 1,1,0));
        // 4-beat frame flagged bad on its last beat
        tab.push_back(mk(1,0,0,0,0,8'h21, 1,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h22, 1,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h23, 1,0,0));
        tab.push_back(mk(1,1,1,0,0,8'h24, 0,0,1));
        // 6-beat frame overflowing at beat 3, then a normal frame
        tab.push_back(mk(1,0,0,0,0,8'h31, 1,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h32, 1,0,0));
        tab.push_back(mk(1,0,0,1,0,8'h33, 0,0,1));
        tab.push_back(mk(1,0,0,0,0,8'h34, 0,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h35, 0,0,0));
        tab.push_back(mk(1,1,0,0,0,8'h36, 0,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h41, 1,0,0));
        tab.push_back(mk(1,1,0,0,0,8'h42, 1,1,0));
        // almost-full at first beat of a 3-beat frame
        tab.push_back(mk(1,0,0,0,1,8'h51, 0,0,0));
        tab.push_back(mk(1,0,0,0,0,8'h52, 0,0,0));
        tab.push_back(mk(1,1,0,0,0,8'h53, 0,0,0));
        // back-to-back single-beat frames: good then bad
        tab.push_back(mk(1,1,0,0,0,8'h61, 1,1,0));
        tab.push_back(mk(1,1,1,0,0,8'h62, 0,0,0));

        reset_n = 1'b0; tvalid = 0; tlast = 0; tuser = 0; full = 0; afull = 0; tdata = '0;
        m_storing = 0; m_discarding = 0; m_good = 0; m_drop = 0;
        repeat (2) @(posedge clk);
        step(0, 1,0,0,0,0, 8'hA5, 0, 0,0,0);
        step(0, 1,1,0,0,0, 8'hA6, 0, 0,0,0);

        foreach (tab[i])
            step(1, tab[i].v, tab[i].l, tab[i].u, tab[i].f, tab[i].af, tab[i].d,
                 1, tab[i].w, tab[i].la, tab[i].dp);
        step(1, 0,0,0,0,0, 8'h00, 0, 0,0,0);
        check("good_after_table", int'(good16), 3);
        check("drop_after_table", int'(drop16), 4);

        // Saturation of the narrow counter with five more bad frames
        for (int i = 0; i < 5; i++)
            step(1, 1,1,1,0,0, 8'h70 + 8'(i), 1, 0,0,0);
        step(1, 0,0,0,0,0, 8'h00, 0, 0,0,0);
        check("drop_sat_hold", int'(drop2), 3);
        check("drop16_after_bad", int'(drop16), 9);

        // Reset mid-frame: abandoned silently, first beat after release accepted
        step(1, 1,0,0,0,0, 8'h81, 1, 1,0,0);
        step(1, 1,0,0,0,0, 8'h82, 1, 1,0,0);
        step(0, 1,1,1,1,0, 8'h83, 1, 0,0,0);
        step(1, 1,1,0,0,0, 8'h91, 1, 1,1,0);
        step(1, 0,0,0,0,0, 8'h00, 0, 0,0,0);
        check("good_after_reset", int'(good16), 1);
        check("drop_after_reset", int'(drop16), 0);

        // Random beats against the reference model
        for (int i = 0; i < 3000; i++) begin
            bit rst, v, l, u, f, af;
            rst = ($urandom_range(0, 199) != 0);
            v   = ($urandom_range(0, 3) != 0);
            l   = ($urandom_range(0, 3) == 0);
            u   = ($urandom_range(0, 4) == 0);
            f   = ($urandom_range(0, 9) == 0);
            af  = ($urandom_range(0, 6) == 0);
            step(rst, v, l, u, f, af, 8'($urandom), 0, 0,0,0);
        end
        step(1, 0,0,0,0,0, 8'h00, 0, 0,0,0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pckt_wr_ctrl.md
FIFO_PCKT_WR_CTRL -- requirements
Module: fifo_pckt_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO word width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_axis_tdata  input  DATA_WIDTH  receive data beat from MAC RX.
REQ-006 SHALL have port s_axis_tvalid  input  1  beat valid.
REQ-007 SHALL have port s_axis_tlast  input  1  last beat of frame.
REQ-008 SHALL have port s_axis_tuser  input  1  bad-frame flag, meaningful only with tlast.
REQ-009 SHALL have port s_axis_tready  output  1  ready; MAC RX cannot stall.
REQ-010 SHALL have port fifo_full  input  1  FIFO full flag, write-clock domain.
REQ-011 SHALL have port fifo_almost_full  input  1  FIFO almost-full flag.
REQ-012 SHALL have port fifo_write  output  1  FIFO write strobe.
REQ-013 SHALL have port fifo_wdata  output  DATA_WIDTH  FIFO write data.
REQ-014 SHALL have port latch_addr  output  1  commit pulse: write pointer after this write becomes the rollback point.
REQ-015 SHALL have port drop_pckt  output  1  rollback pulse: write pointer restored to last committed point.
REQ-016 SHALL have port good_cnt  output  CNT_WIDTH  committed-frame count, saturating.
REQ-017 SHALL have port drop_cnt  output  CNT_WIDTH  dropped-frame count, saturating.

Function
REQ-018 SHALL implement FSM states IDLE (awaiting first beat), WRITE (mid-frame, beats stored), DROP (mid-frame, beats discarded).
REQ-019 SHALL drive fifo_write, fifo_wdata, latch_addr, drop_pckt combinationally from current state and current beat (zero latency); state and counters registered.
REQ-020 SHALL set fifo_wdata = s_axis_tdata at all times.
REQ-021 SHALL hold s_axis_tready 0 in reset, 1 at all other times.
REQ-022 IDLE, tvalid, !tlast: if fifo_almost_full -> no write, go DROP; else write beat, go WRITE.
REQ-023 IDLE, tvalid, tlast, !tuser, !fifo_almost_full: write beat, assert latch_addr same cycle, good_cnt+1, stay IDLE.
REQ-024 IDLE, tvalid, tlast, (tuser or fifo_almost_full): no write, no drop_pckt, drop_cnt+1, stay IDLE.
REQ-025 WRITE, tvalid, !tlast, !fifo_full: write beat, stay WRITE.
REQ-026 WRITE, tvalid, !tlast, fifo_full: no write, drop_pckt one cycle, go DROP.
REQ-027 WRITE, tvalid, tlast, !tuser, !fifo_full: write beat with latch_addr same cycle, good_cnt+1, go IDLE.
REQ-028 WRITE, tvalid, tlast, (tuser or fifo_full): no write, drop_pckt one cycle, drop_cnt+1, go IDLE.
REQ-029 DROP: no write, no drop_pckt; on tvalid&tlast drop_cnt+1, go IDLE; else stay DROP.
REQ-030 !tvalid in any state: no outputs asserted, state unchanged.
REQ-031 fifo_write and drop_pckt SHALL never be asserted in the same cycle; latch_addr SHALL only be asserted with fifo_write.
REQ-032 Counters SHALL saturate at 2**CNT_WIDTH-1, no wrap.

Reset
REQ-033 reset_n low SHALL force state IDLE, good_cnt=0, drop_cnt=0, s_axis_tready=0; fifo_write, latch_addr, drop_pckt low while in reset.
REQ-034 Reset mid-frame SHALL abandon the frame without drop_pckt; the downstream pointer resets in the same cycle.
REQ-035 First cycle after reset release SHALL accept a beat in IDLE.

Structure
REQ-036 FSM state enum (IDLE, WRITE, DROP) SHALL live in shared package eth_fifo_pkg.
REQ-037 Saturating counter SHALL be one sub-module, sat_counter (parameter WIDTH; inputs clk, reset_n, inc; output count), instantiated twice.

Verification
REQ-038 5-beat frame 0x11..0x15, tuser=0, FIFO empty -> 5 fifo_write pulses, latch_addr on beat 5 only, good_cnt=1.
REQ-039 4-beat frame, tlast beat tuser=1 -> 3 writes, beat 4 not written, drop_pckt one cycle on beat 4, drop_cnt=1.
REQ-040 fifo_full rises at beat 3 of 6 -> writes beats 1-2, drop_pckt at beat 3, beats 4-6 discarded, drop_cnt=1, next frame written normally.
REQ-041 fifo_almost_full=1 at first beat of 3-beat frame -> zero writes, no drop_pckt, drop_cnt=1.
REQ-042 Single-beat frames back-to-back: good then bad -> one write with latch_addr, then none; good_cnt=1, drop_cnt=1.
REQ-043 CNT_WIDTH=2, 5 bad frames -> drop_cnt saturates at 3; reset mid-frame -> state IDLE, counters 0, no drop_pckt.
